keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Drives the column lines of the 4x3 membrane keypad, samples the row lines, debounces a single key press and presents it as registered one-hot `row1..row4` / `col1..col3` levels with a one-cycle `key_valid` strobe. It sits directly upstream of `KeypadToBcdEncoder`, which turns those one-hot lines into BCD. `key_valid` qualifies the encoder output for the downstream digit-entry logic.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven while scanning; legal range is 4 or more.
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles required to accept a press and to accept a release; legal range is 2 or more.
- `clk`  in  1  the only clock; all flops are rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row_sense_n`  in  4  raw keypad rows, active-low and pulled up; bit 0 is row 1 (keys 1 2 3), bit 3 is row 4 (keys * 0 #). Asynchronous to `clk`.
- `col_drive_n`  out  3  one-cold column drive; bit 0 is column 1 (left).
- `row1`..`row4`  out  1 each  one-hot row of the last accepted key.
- `col1`..`col3`  out  1 each  one-hot column of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_held`  out  1  high from acceptance until the release is debounced.

## Operation
- All `row_sense_n` bits pass through a 2-flop synchronizer. The state machine uses only the synchronized value `rs`.
- The column index `ci` is held in a 2-bit register, cycling 0→1→2→0. `col_drive_n` is all ones except a 0 at bit `ci`, and is registered.
- `cnt` is a shared counter with width $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)+1).
- "Advance" means: `ci` moves to the next column and `cnt` clears to 0.
- **SCAN**
  - `cnt` increments each cycle.
  - When `cnt`==SCAN_DIV-1, `rs` is evaluated:
    - exactly one bit low: latch `cand_row` and `cand_col`=`ci`, clear `cnt`, go to DEBOUNCE (column stays driven).
    - no bit low, or two or more bits low (multi-key or ghost): advance and stay in SCAN.
- **DEBOUNCE**
  - `rs` equals the candidate pattern: `cnt` increments.
  - Any difference: advance and return to SCAN.
  - `cnt` reaching DEBOUNCE_CYCLES-1 with a match: go to REPORT.
- **REPORT** (exactly one cycle)
  - `row1..row4` and `col1..col3` load the one-hot decode of `cand_row` and `cand_col`.
  - `key_valid`=1 and `key_held`=1.
  - `cnt` clears and the state moves to RELEASE.
- **RELEASE**
  - The column stays driven.
  - All `rs` bits high: `cnt` increments. Any bit low: `cnt` clears.
  - `cnt` reaching DEBOUNCE_CYCLES-1 with all bits high: `key_held`=0, advance, go to SCAN.
- `row*` and `col*` hold the last accepted key until the next REPORT; they never return to zero except through reset.
- A second key pressed while in RELEASE is ignored. Only the release of all keys re-arms the scanner.

## Timing
- Reset values: state=SCAN, `ci`=0, `col_drive_n`=3'b110, `cnt`=0, synchronizer flops=4'b1111, and `row1..4`, `col1..3`, `key_valid`, `key_held` all 0.
- Reset takes effect immediately from any state, including mid-DEBOUNCE or RELEASE. A key still held when reset is released is reported again after a fresh debounce.
- `key_valid` and the new `row*`/`col*` values appear on the same clock edge, so the encoder output is valid during the `key_valid` cycle.
- Press-to-`key_valid` latency for a clean, stable press: at least 2+DEBOUNCE_CYCLES+1 cycles and at most 3·SCAN_DIV+2+DEBOUNCE_CYCLES+1 cycles.
- After a clean release, `key_held` falls 2+DEBOUNCE_CYCLES cycles after `row_sense_n` goes all-high.
- At most one `key_valid` is produced per physical press, regardless of bounce.

## Structure
- Shared package `keypad_pkg` holds:
  - the state encoding (SCAN=2'd0, DEBOUNCE=2'd1, REPORT=2'd2, RELEASE=2'd3);
  - SYNC_STAGES=2;
  - NUM_ROWS=4 and NUM_COLS=3;
  - the one-cold column drive constants.
- One sub-module, `sync_2ff`: a parameterised-width 2-flop synchronizer with reset value all ones, instantiated at width 4 for the rows.
- The state machine, counter and output registers stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8. The keypad model pulls `row_sense_n[r]` low when key (r,c) is pressed and `col_drive_n[c]`=0.

- **Reset:** hold `rst_n`=0 mid-scan → `col_drive_n`=3'b110 and all outputs 0 during reset and on the first cycle after release.
- **Clean press:** press key 5 (row 2, col 2) for 100 cycles, then release → exactly one `key_valid`, with `row2`=`col2`=1 and all other row/col outputs 0. `key_held` is high throughout the press and falls 10 cycles after release; `row2`/`col2` stay at 1 afterwards.
- **Bounce:** key 9 toggles every 3 cycles for 30 cycles, then stays pressed → exactly one `key_valid`, with `row3`=`col3`=1.
- **Short glitch:** key 1 pressed for 5 cycles → no `key_valid`, and `col_drive_n` keeps cycling 110→101→011.
- **Multi-key:** keys 1 and 7 (both column 1) pressed together → no `key_valid` while both are down. Release key 7 → one `key_valid` with `row1`=`col1`=1.
- **Reset in RELEASE:** key 0 (row 4, col 2) accepted, assert `rst_n` low while the key is still held → outputs clear at once. After reset is released, a second `key_valid` with `row4`=`col2`=1 follows the debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg: shared state encoding, sizes and column-drive helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      REPORT   = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam int SYNC_STAGES = 2;
   localparam int NUM_ROWS    = 4;
   localparam int NUM_COLS    = 3;

   localparam logic [NUM_COLS-1:0] COL1_DRIVE_N = 3'b110;
   localparam logic [NUM_COLS-1:0] COL2_DRIVE_N = 3'b101;
   localparam logic [NUM_COLS-1:0] COL3_DRIVE_N = 3'b011;
   localparam logic [NUM_COLS-1:0] COL_IDLE_N   = 3'b111;

   function automatic logic [NUM_COLS-1:0] col_drive_of(input logic [1:0] ci);
      case (ci)
         2'd0:    return COL1_DRIVE_N;
         2'd1:    return COL2_DRIVE_N;
         2'd2:    return COL3_DRIVE_N;
         default: return COL_IDLE_N;
      endcase
   endfunction

   function automatic logic [1:0] next_col(input logic [1:0] ci);
      return (ci == 2'd2) ? 2'd0 : ci + 2'd1;
   endfunction

   // True when exactly one active-low row line is asserted.
   function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
      case (rows)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_sync_2ff.sv
// ============================================================================
// sync_2ff: parameterised-width two-flop synchronizer, resets to all ones
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff
   import keypad_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '1;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner: 4x3 keypad column scan, debounce and one-hot key report
// Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_ROWS-1:0] row_sense_n,
   output logic [NUM_COLS-1:0] col_drive_n,
   output logic                row1,
   output logic                row2,
   output logic                row3,
   output logic                row4,
   output logic                col1,
   output logic                col2,
   output logic                col3,
   output logic                key_valid,
   output logic                key_held
);

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_ROWS-1:0] rs;
   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [1:0]          ci, ci_n;
   logic [NUM_ROWS-1:0] cand_row, cand_row_n;
   logic [1:0]          cand_col, cand_col_n;
   logic [NUM_ROWS-1:0] row_oh;
   logic [NUM_COLS-1:0] col_oh;
   logic                load_key;
   logic                release_done;

   sync_2ff #(
      .WIDTH (NUM_ROWS)
   ) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_sense_n),
      .q     (rs)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SCAN;
      else        state <= state_n;
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      ci_n         = ci;
      cand_row_n   = cand_row;
      cand_col_n   = cand_col;
      load_key     = 1'b0;
      release_done = 1'b0;
      case (state)
         SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_n = '0;
               if (single_low(rs)) begin
                  cand_row_n = rs;
                  cand_col_n = ci;
                  state_n    = DEBOUNCE;
               end else begin
                  ci_n = next_col(ci);
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs != cand_row) begin
               ci_n    = next_col(ci);
               cnt_n   = '0;
               state_n = SCAN;
            end else if (cnt == DEB_LAST) begin
               load_key = 1'b1;
               state_n  = REPORT;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         REPORT: begin
            cnt_n   = '0;
            state_n = RELEASE;
         end
         RELEASE: begin
            // Any key still down, including a newly pressed one, restarts the release window.
            if (rs != '1) begin
               cnt_n = '0;
            end else if (cnt == DEB_LAST) begin
               release_done = 1'b1;
               ci_n         = next_col(ci);
               cnt_n        = '0;
               state_n      = SCAN;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = SCAN;
            cnt_n   = '0;
         end
      endcase
   end

   // Key outputs load on the edge entering REPORT so key_valid and the one-hot lines coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         ci          <= 2'd0;
         cand_row    <= '1;
         cand_col    <= 2'd0;
         col_drive_n <= COL1_DRIVE_N;
         row_oh      <= '0;
         col_oh      <= '0;
         key_valid   <= 1'b0;
         key_held    <= 1'b0;
      end else begin
         cnt         <= cnt_n;
         ci          <= ci_n;
         cand_row    <= cand_row_n;
         cand_col    <= cand_col_n;
         col_drive_n <= col_drive_of(ci_n);
         key_valid   <= load_key;
         if (load_key) begin
            row_oh   <= ~cand_row;
            col_oh   <= ~col_drive_of(cand_col);
            key_held <= 1'b1;
         end else if (release_done) begin
            key_held <= 1'b0;
         end
      end
   end

   assign row1 = row_oh[0];
   assign row2 = row_oh[1];
   assign row3 = row_oh[2];
   assign row4 = row_oh[3];
   assign col1 = col_oh[0];
   assign col2 = col_oh[1];
   assign col3 = col_oh[2];

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner: keypad-model bench with vector table and random presses
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int LAT_MIN  = 2 + DEB + 1;
   localparam int LAT_MAX  = 3 * SCAN_DIV + 2 + DEB + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row_sense_n;
   logic [2:0]  col_drive_n;
   logic        row1, row2, row3, row4, col1, col2, col3;
   logic        key_valid, key_held;
   logic [11:0] pressed;

   int          checks = 0;
   int          errors = 0;
   int          valid_cnt = 0;
   logic [3:0]  cap_row = '0;
   logic [2:0]  cap_col = '0;
   logic        cap_held = 1'b0;

   wire [3:0] rows = {row4, row3, row2, row1};
   wire [2:0] cols = {col3, col2, col1};
   wire [8:0] outs = {rows, cols, key_valid, key_held};

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_sense_n (row_sense_n),
      .col_drive_n (col_drive_n),
      .row1        (row1),
      .row2        (row2),
      .row3        (row3),
      .row4        (row4),
      .col1        (col1),
      .col2        (col2),
      .col3        (col3),
      .key_valid   (key_valid),
      .key_held    (key_held)
   );

   // Key index r*3+c pulls row r low whenever its column is driven.
   always_comb begin
      row_sense_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r*3+c] && !col_drive_n[c]) row_sense_n[r] = 1'b0;
   end

   always begin
      @(posedge clk);
      #1;
      if (key_valid) begin
         valid_cnt = valid_cnt + 1;
         cap_row   = rows;
         cap_col   = cols;
         cap_held  = key_held;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input int base, input int limit, output int n);
      n = 0;
      while (valid_cnt == base && n < limit) begin
         @(negedge clk);
         n = n + 1;
      end
      check("key_valid_seen", valid_cnt != base, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [11:0] mask;
      int          hold;
      int          pulses;
      logic [3:0]  row;
      logic [2:0]  col;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int         base;
      int         n;
      int         trans;
      logic [2:0] prev;
      logic [3:0] exp_row;
      logic [2:0] exp_col;

      tbl[0] = '{12'h010, 100, 1, 4'b0010, 3'b010};
      tbl[1] = '{12'h001,   5, 0, 4'b0010, 3'b010};
      tbl[2] = '{12'h800,  60, 1, 4'b1000, 3'b100};
      tbl[3] = '{12'h041,  80, 0, 4'b1000, 3'b100};
      tbl[4] = '{12'h200,  60, 1, 4'b1000, 3'b001};
      tbl[5] = '{12'h004,  60, 1, 4'b0001, 3'b100};

      pressed = '0;
      rst_n   = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(6);
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_outs", outs, 9'h0);
      check("reset_async_cols", col_drive_n, 3'b110);
      @(negedge clk);
      check("reset_hold_outs", outs, 9'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_after_outs", outs, 9'h0);
      check("reset_after_cols", col_drive_n, 3'b110);
      idle(5);

      // Clean press of key 5 with latency and release timing.
      base    = valid_cnt;
      pressed = 12'h010;
      wait_valid(base, 40, n);
      check("press_latency_min", n >= LAT_MIN, 1);
      check("press_latency_max", n <= LAT_MAX, 1);
      check("press_row", cap_row, 4'b0010);
      check("press_col", cap_col, 3'b010);
      check("press_held_at_valid", cap_held, 1);
      idle(100 - n);
      check("press_held", key_held, 1);
      pressed = '0;
      idle(9);
      check("release_held_before", key_held, 1);
      idle(1);
      check("release_held_after", key_held, 0);
      idle(10);
      check("press_pulses", valid_cnt - base, 1);
      check("press_row_persist", rows, 4'b0010);
      check("press_col_persist", cols, 3'b010);

      for (int i = 0; i < 6; i++) begin
         base    = valid_cnt;
         pressed = tbl[i].mask;
         idle(tbl[i].hold);
         check("tbl_held", key_held, (tbl[i].pulses != 0) ? 1 : 0);
         pressed = '0;
         idle(30);
         check("tbl_pulses", valid_cnt - base, tbl[i].pulses);
         check("tbl_row", rows, tbl[i].row);
         check("tbl_col", cols, tbl[i].col);
         check("tbl_released", key_held, 0);
      end

      // Short glitch on key 1 must leave the scan running.
      base    = valid_cnt;
      pressed = 12'h001;
      idle(5);
      pressed = '0;
      idle(6);
      prev  = col_drive_n;
      trans = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (col_drive_n != prev) begin
            check("glitch_col_cycle", col_drive_n, {prev[1:0], prev[2]});
            prev  = col_drive_n;
            trans = trans + 1;
         end
      end
      check("glitch_col_moves", trans >= 3, 1);
      check("glitch_no_valid", valid_cnt - base, 0);

      // Key 9 bounces before settling.
      base = valid_cnt;
      for (int k = 0; k < 10; k++) begin
         pressed = (k % 2 == 0) ? 12'h100 : 12'h000;
         idle(3);
      end
      pressed = 12'h100;
      wait_valid(base, 40, n);
      idle(20);
      check("bounce_pulses", valid_cnt - base, 1);
      check("bounce_row", rows, 4'b0100);
      check("bounce_col", cols, 3'b100);
      pressed = '0;
      idle(20);

      // Keys 1 and 7 share a column; releasing 7 leaves key 1 alone.
      base    = valid_cnt;
      pressed = 12'h041;
      idle(60);
      check("multi_no_valid", valid_cnt - base, 0);
      pressed = 12'h001;
      wait_valid(base, 40, n);
      idle(20);
      check("multi_pulses", valid_cnt - base, 1);
      check("multi_row", rows, 4'b0001);
      check("multi_col", cols, 3'b001);
      pressed = '0;
      idle(20);

      // Reset while key 0 is held in the release wait.
      base    = valid_cnt;
      pressed = 12'h400;
      wait_valid(base, 40, n);
      check("rr_first_row", cap_row, 4'b1000);
      idle(5);
      #2 rst_n = 1'b0;
      #1;
      check("rr_outs_cleared", outs, 9'h0);
      check("rr_cols_reset", col_drive_n, 3'b110);
      @(negedge clk);
      rst_n = 1'b1;
      base  = valid_cnt;
      wait_valid(base, 40, n);
      check("rr_second_latency", n >= LAT_MIN, 1);
      check("rr_second_row", cap_row, 4'b1000);
      check("rr_second_col", cap_col, 3'b010);
      pressed = '0;
      idle(20);

      // Random presses: long stable presses are accepted once, short ones never.
      exp_row = 4'b1000;
      exp_col = 3'b010;
      for (int t = 0; t < 30; t++) begin
         int          key;
         bit          long_press;
         int          nb;
         logic [11:0] m;
         key        = $urandom_range(0, 11);
         long_press = ($urandom_range(0, 2) != 0);
         m          = 12'b1 << key;
         base       = valid_cnt;
         if (long_press) begin
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) begin
               pressed = m;
               idle($urandom_range(1, 3));
               pressed = '0;
               idle($urandom_range(1, 3));
            end
            pressed = m;
            idle($urandom_range(30, 50));
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) begin
               pressed = '0;
               idle($urandom_range(1, 3));
               pressed = m;
               idle($urandom_range(1, 3));
            end
            pressed = '0;
            exp_row = 4'b1 << (key / 3);
            exp_col = 3'b1 << (key % 3);
         end else begin
            pressed = m;
            idle($urandom_range(1, 6));
            pressed = '0;
         end
         idle($urandom_range(16, 30));
         check("rand_pulses", valid_cnt - base, long_press ? 1 : 0);
         check("rand_row", rows, exp_row);
         check("rand_col", cols, exp_col);
         check("rand_released", key_held, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
